// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one 32-bit carry-lookahead adder between NREQ requesters.
// The sum, flags and owner tag are registered behind a valid/ready handshake.
module adder_arbiter #(
    parameter int NREQ = 2,
    parameter int TAGW = 1
) (
    input  logic                 iClk,
    input  logic                 inRst,
    input  logic [NREQ-1:0]      iReq,
    input  logic [NREQ*32-1:0]   iX,
    input  logic [NREQ*32-1:0]   iY,
    input  logic [NREQ-1:0]      iCarry,
    input  logic [NREQ-1:0]      iSub,
    output logic [NREQ-1:0]      oGnt,
    input  logic                 iRdy,
    output logic                 oValid,
    output logic [TAGW-1:0]      oTag,
    output logic [31:0]          oS,
    output logic                 oCarry,
    output logic                 oOverflow,
    output logic                 oZero,
    output logic                 oNegative
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // Returns {c31, c32, sum}; 4-bit lookahead groups chained by group carry.
    function automatic logic [33:0] cla32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
        logic [31:0] g;
        logic [31:0] p;
        logic [32:0] c;
        int          b0;
        g    = a & b;
        p    = a ^ b;
        c    = 33'd0;
        c[0] = cin;
        for (int blk = 0; blk < 8; blk++) begin
            b0 = blk * 4;
            c[b0+1] = g[b0] | (p[b0] & c[b0]);
            c[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & c[b0]);
            c[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+2] & p[b0+1] & p[b0] & c[b0]);
            c[b0+4] = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & p[b0] & c[b0]);
        end
        return {c[31], c[32], p ^ c[31:0]};
    endfunction

    logic [0:0]      state_r;
    logic [0:0]      state_next_s;
    logic [TAGW-1:0] ptr_r;
    logic [TAGW-1:0] tag_r;
    logic [31:0]     s_r;
    logic            carry_r;
    logic            overflow_r;
    logic            zero_r;
    logic            negative_r;

    logic            acc_s;
    logic [NREQ-1:0] sel_s;
    logic [TAGW-1:0] gidx_s;
    logic [NREQ-1:0] gnt_s;
    logic            any_gnt_s;
    logic [31:0]     x_s;
    logic [31:0]     y_s;
    logic            sub_s;
    logic            cin_s;
    logic [33:0]     add_s;

    assign acc_s = (state_r == EMPTY) || iRdy;

    // Round-robin pick: first request at or above ptr, otherwise the lowest request (wrap).
    always_comb begin
        logic found;
        found  = 1'b0;
        sel_s  = '0;
        gidx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && iReq[k] && (TAGW'(k) >= ptr_r)) begin
                found    = 1'b1;
                sel_s[k] = 1'b1;
                gidx_s   = TAGW'(k);
            end else begin
                found = found;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && iReq[k]) begin
                found    = 1'b1;
                sel_s[k] = 1'b1;
                gidx_s   = TAGW'(k);
            end else begin
                found = found;
            end
        end
    end

    assign gnt_s     = (acc_s && inRst) ? sel_s : '0;
    assign any_gnt_s = |gnt_s;
    assign oGnt      = gnt_s;

    // One-hot operand mux feeding the shared adder.
    always_comb begin
        x_s   = 32'd0;
        y_s   = 32'd0;
        sub_s = 1'b0;
        cin_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            x_s   = x_s | ({32{sel_s[k]}} & iX[32*k +: 32]);
            y_s   = y_s | ({32{sel_s[k]}} & iY[32*k +: 32]);
            sub_s = sub_s | (sel_s[k] & iSub[k]);
            cin_s = cin_s | (sel_s[k] & iCarry[k]);
        end
    end

    assign add_s = cla32(x_s, sub_s ? ~y_s : y_s, sub_s ? 1'b1 : cin_s);

    // Next-state logic for the result register occupancy.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (any_gnt_s) state_next_s = FULL;
                else           state_next_s = EMPTY;
            end
            FULL: begin
                if (iRdy && !any_gnt_s) state_next_s = EMPTY;
                else                    state_next_s = FULL;
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // Result register, pointer and state update.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            state_r    <= EMPTY;
            ptr_r      <= '0;
            tag_r      <= '0;
            s_r        <= 32'd0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (any_gnt_s) begin
                tag_r      <= gidx_s;
                s_r        <= add_s[31:0];
                carry_r    <= add_s[32];
                overflow_r <= add_s[32] ^ add_s[33];
                zero_r     <= (add_s[31:0] == 32'd0);
                negative_r <= add_s[31];
                ptr_r      <= (gidx_s == TAGW'(NREQ - 1)) ? '0 : gidx_s + TAGW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign oValid    = (state_r == FULL);
    assign oTag      = tag_r;
    assign oS        = s_r;
    assign oCarry    = carry_r;
    assign oOverflow = overflow_r;
    assign oZero     = zero_r;
    assign oNegative = negative_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a 2-requester instance plus a 3-requester instance for wrap.
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic        rdy;

    logic [1:0]  req_a;
    logic [63:0] x_a;
    logic [63:0] y_a;
    logic [1:0]  cin_a;
    logic [1:0]  sub_a;
    logic [1:0]  gnt_a;
    logic        valid_a;
    logic [0:0]  tag_a;
    logic [31:0] s_a;
    logic        c_a, ov_a, z_a, n_a;

    logic [2:0]  req_b;
    logic [95:0] x_b;
    logic [95:0] y_b;
    logic [2:0]  cin_b;
    logic [2:0]  sub_b;
    logic [2:0]  gnt_b;
    logic        valid_b;
    logic [1:0]  tag_b;
    logic [31:0] s_b;
    logic        c_b, ov_b, z_b, n_b;

    int checks = 0;
    int fails  = 0;

    adder_arbiter #(.NREQ(2), .TAGW(1)) dut_a (
        .iClk(clk), .inRst(rst_n), .iReq(req_a), .iX(x_a), .iY(y_a),
        .iCarry(cin_a), .iSub(sub_a), .oGnt(gnt_a), .iRdy(rdy), .oValid(valid_a),
        .oTag(tag_a), .oS(s_a), .oCarry(c_a), .oOverflow(ov_a), .oZero(z_a),
        .oNegative(n_a)
    );

    adder_arbiter #(.NREQ(3), .TAGW(2)) dut_b (
        .iClk(clk), .inRst(rst_n), .iReq(req_b), .iX(x_b), .iY(y_b),
        .iCarry(cin_b), .iSub(sub_b), .oGnt(gnt_b), .iRdy(1'b1), .oValid(valid_b),
        .oTag(tag_b), .oS(s_b), .oCarry(c_b), .oOverflow(ov_b), .oZero(z_b),
        .oNegative(n_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] s,
                         input logic t, input logic c, input logic ov, input logic z,
                         input logic n);
        chk({tag, ".valid"}, {31'd0, valid_a}, {31'd0, v});
        chk({tag, ".s"}, s_a, s);
        chk({tag, ".tag"}, {31'd0, tag_a}, {31'd0, t});
        chk({tag, ".flags"}, {28'd0, c_a, ov_a, z_a, n_a}, {28'd0, c, ov, z, n});
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        req_a = 2'b11; x_a = 64'd0; y_a = 64'd0; cin_a = 2'b00; sub_a = 2'b00;
        req_b = 3'b000; x_b = 96'd0; y_b = 96'd0; cin_b = 3'b000; sub_b = 3'b000;
        #3;
        chk_a("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.gnt", {30'd0, gnt_a}, 32'd0);
        tick();
        rst_n = 1'b1;

        // R0: 0xFFFFFFFF + 1 wraps to zero with carry out.
        req_a = 2'b01; x_a[31:0] = 32'hFFFF_FFFF; y_a[31:0] = 32'd1;
        #1 chk("add_wrap.gnt", {30'd0, gnt_a}, 32'd1);
        tick();
        chk_a("add_wrap", 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // R1: 5 - 7 borrows.
        req_a = 2'b10; x_a[63:32] = 32'd5; y_a[63:32] = 32'd7; sub_a = 2'b10;
        #1 chk("sub.gnt", {30'd0, gnt_a}, 32'd2);
        tick();
        chk_a("sub", 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // R1: 0x7FFFFFFF + 1 signed overflow.
        x_a[63:32] = 32'h7FFF_FFFF; y_a[63:32] = 32'd1; sub_a = 2'b00;
        #1 chk("ovf.gnt", {30'd0, gnt_a}, 32'd2);
        tick();
        chk_a("ovf", 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Both request, ptr=0: R0 computes 1+2+1=4, R1 computes 10-3=7.
        req_a = 2'b11; x_a = {32'd10, 32'd1}; y_a = {32'd3, 32'd2};
        cin_a = 2'b01; sub_a = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1 chk("rr.gnt", {30'd0, gnt_a}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            if (i % 2 == 0) chk_a("rr0", 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else            chk_a("rr1", 1'b1, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Consumer stalls: no grants, result held.
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall.gnt", {30'd0, gnt_a}, 32'd0);
            tick();
            chk_a("stall", 1'b1, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        rdy = 1'b1;
        #1 chk("resume.gnt", {30'd0, gnt_a}, 32'd1);
        tick();
        chk_a("resume", 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Drain to EMPTY, then accept with rdy low since the register is empty.
        req_a = 2'b00;
        #1 chk("drain.gnt", {30'd0, gnt_a}, 32'd0);
        tick();
        chk("drain.valid", {31'd0, valid_a}, 32'd0);
        req_a = 2'b10; rdy = 1'b0;
        #1 chk("empty_acc.gnt", {30'd0, gnt_a}, 32'd2);
        tick();
        chk_a("empty_acc", 1'b1, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while FULL.
        req_a = 2'b00;
        #2 rst_n = 1'b0;
        #1 chk_a("async_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1; rdy = 1'b1; req_a = 2'b11;
        #1 chk("post_rst.gnt", {30'd0, gnt_a}, 32'd1);
        tick();
        chk_a("post_rst", 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        req_a = 2'b00;

        // NREQ=3: only R2 from ptr=0, then R0+R2 must pick R0 after wrap.
        req_b = 3'b100; x_b[95:64] = 32'd3; y_b[95:64] = 32'd4; x_b[31:0] = 32'd9;
        #1 chk("n3_r2.gnt", {29'd0, gnt_b}, 32'd4);
        tick();
        chk("n3_r2.tag", {30'd0, tag_b}, 32'd2);
        chk("n3_r2.s", s_b, 32'd7);
        req_b = 3'b101;
        #1 chk("n3_wrap.gnt", {29'd0, gnt_b}, 32'd1);
        tick();
        chk("n3_wrap.tag", {30'd0, tag_b}, 32'd0);
        chk("n3_wrap.s", s_b, 32'd9);
        chk("n3_wrap.valid", {31'd0, valid_b}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
